// File: rtl/sdf_r2_stage_d2.sv
// Radix-2 SDF stage, 2-deep delay feedback, W4 twiddles {1,-j}, self-sequenced phase
// counter with valid/flush handshake. Output grows by one bit.
module sdf_r2_stage_d2 #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH:0]   out_re,
    output logic [WIDTH:0]   out_im,
    output logic             sof_err
);
    localparam int OW = WIDTH + 1;

    logic [1:0]          cnt_q, cnt_d;
    logic [1:0][OW-1:0]  dl_re_q, dl_re_d, dl_im_q, dl_im_d;
    logic [1:0]          dl_vld_q, dl_vld_d;
    logic                out_valid_q, out_valid_d;
    logic [OW-1:0]       out_re_q, out_re_d, out_im_q, out_im_d;
    logic                sof_err_q, sof_err_d;

    logic                adv, sof_mid;
    logic [1:0]          ph, vld_eff;
    logic [OW-1:0]       in_re_x, in_im_x, head_re, head_im;

    always_comb begin
        adv      = in_valid | (flush & ~cnt_q[1]);
        sof_mid  = in_valid & in_sof & (cnt_q != 2'd0);
        // A start-of-frame always restarts at phase 0; a misplaced one also drops pending data.
        ph       = (in_valid & in_sof) ? 2'd0 : cnt_q;
        vld_eff  = sof_mid ? 2'b00 : dl_vld_q;
        in_re_x  = OW'(signed'(in_re));
        in_im_x  = OW'(signed'(in_im));
        head_re  = dl_re_q[1];
        head_im  = dl_im_q[1];

        cnt_d       = cnt_q;
        dl_re_d     = dl_re_q;
        dl_im_d     = dl_im_q;
        dl_vld_d    = dl_vld_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        sof_err_d   = sof_mid;

        if (adv) begin
            cnt_d       = ph + 2'd1;
            dl_re_d[1]  = dl_re_q[0];
            dl_im_d[1]  = dl_im_q[0];
            dl_vld_d[1] = vld_eff[0];
            out_valid_d = vld_eff[1];
            if (!ph[1]) begin
                // Fill: emit the stored difference, twiddled on the way out.
                if (ph[0]) begin
                    out_re_d = head_im;
                    out_im_d = -head_re;
                end else begin
                    out_re_d = head_re;
                    out_im_d = head_im;
                end
                dl_re_d[0]  = in_valid ? in_re_x : '0;
                dl_im_d[0]  = in_valid ? in_im_x : '0;
                dl_vld_d[0] = in_valid;
            end else begin
                out_re_d    = head_re + in_re_x;
                out_im_d    = head_im + in_im_x;
                dl_re_d[0]  = head_re - in_re_x;
                dl_im_d[0]  = head_im - in_im_x;
                dl_vld_d[0] = vld_eff[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            dl_re_q     <= '0;
            dl_im_q     <= '0;
            dl_vld_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            sof_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dl_re_q     <= dl_re_d;
            dl_im_q     <= dl_im_d;
            dl_vld_q    <= dl_vld_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign sof_err   = sof_err_q;
endmodule

// File: tb/tb_sdf_r2_stage_d2.sv
// Bench for sdf_r2_stage_d2: frame-level radix-2 reference schedules each frame's
// sums and twiddled differences against the advance index at which they must appear.
module tb_sdf_r2_stage_d2;
    localparam int WIDTH = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_sof, flush;
    logic [WIDTH-1:0] in_re, in_im;
    logic             out_valid, sof_err;
    logic [WIDTH:0]   out_re, out_im;

    int checks   = 0;
    int failures = 0;

    // Reference: phase, advance count, current frame samples, scheduled outputs by advance index.
    int ph, advn;
    int x_re[4], x_im[4];
    bit fr_ok;
    int s_re[int], s_im[int];

    sdf_r2_stage_d2 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .flush(flush),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    function automatic int rnd_s();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    task automatic model_reset();
        ph = 0; advn = 0; fr_ok = 0;
        s_re.delete(); s_im.delete();
    endtask

    task automatic step(input bit v, input bit sof, input int re, input int im, input bit fl,
                        input string tag);
        bit adv, expv, experr;
        int ere, eim, are, aim;
        adv = v || (fl && ph < 2);
        experr = v && sof && ph != 0;
        expv = 0; ere = 0; eim = 0;
        if (adv) begin
            if (v && sof) begin
                if (ph != 0)
                    for (int k = advn; k < advn + 8; k++) begin
                        if (s_re.exists(k)) begin s_re.delete(k); s_im.delete(k); end
                    end
                ph = 0;
            end
            if (ph == 0) fr_ok = 1;
            if (!v) fr_ok = 0;
            x_re[ph] = v ? re : 0;
            x_im[ph] = v ? im : 0;
            if (ph == 2 && fr_ok) begin
                s_re[advn] = x_re[0] + x_re[2];
                s_im[advn] = x_im[0] + x_im[2];
            end
            if (ph == 3 && fr_ok) begin
                s_re[advn]   = x_re[1] + x_re[3];
                s_im[advn]   = x_im[1] + x_im[3];
                s_re[advn+1] = x_re[0] - x_re[2];
                s_im[advn+1] = x_im[0] - x_im[2];
                s_re[advn+2] = x_im[1] - x_im[3];
                s_im[advn+2] = -(x_re[1] - x_re[3]);
            end
            if (s_re.exists(advn)) begin
                expv = 1; ere = s_re[advn]; eim = s_im[advn];
                s_re.delete(advn); s_im.delete(advn);
            end
            ph = (ph + 1) % 4;
            advn++;
        end
        in_valid = v; in_sof = sof; flush = fl;
        in_re = re[WIDTH-1:0]; in_im = im[WIDTH-1:0];
        @(posedge clk); #1;
        checks++;
        if (out_valid !== expv) begin
            failures++;
            $display("FAIL %s out_valid adv=%0d got=%b exp=%b", tag, advn, out_valid, expv);
        end
        checks++;
        if (sof_err !== experr) begin
            failures++;
            $display("FAIL %s sof_err adv=%0d got=%b exp=%b", tag, advn, sof_err, experr);
        end
        if (expv) begin
            are = int'($signed(out_re)); aim = int'($signed(out_im));
            checks++;
            if (are !== ere || aim !== eim) begin
                failures++;
                $display("FAIL %s data adv=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                         tag, advn, are, aim, ere, eim);
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, rnd_s(), rnd_s(), 0, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom); in_sof = 1'($urandom); flush = 1'($urandom);
            in_re = WIDTH'($urandom); in_im = WIDTH'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || out_re !== '0 || out_im !== '0 || sof_err !== 1'b0) begin
                failures++;
                $display("FAIL reset got v=%b re=%0d im=%0d err=%b exp all zero",
                         out_valid, out_re, out_im, sof_err);
            end
        end
        rst = 1'b0; in_valid = 0; in_sof = 0; flush = 0;
        model_reset();
    endtask

    task automatic frame(input int n, input bit gaps, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1, i == 0, rnd_s(), rnd_s(), 0, tag);
            if (gaps) begin
                int g = int'($urandom_range(0, 3));
                for (int j = 0; j < g; j++)
                    step(0, 0, rnd_s(), rnd_s(), (ph >= 2) ? 1'($urandom) : 1'b0, tag);
            end
        end
    endtask

    task automatic test_basic_frame();
        test_reset();
        step(1, 1, 1, 0, 0, "basic");
        step(1, 0, 2, 0, 0, "basic");
        step(1, 0, 3, 0, 0, "basic");
        step(1, 0, 4, 0, 0, "basic");
        step(0, 0, 0, 0, 1, "basic_flush");
        step(0, 0, 0, 0, 1, "basic_flush");
        idle("basic_idle");
    endtask

    task automatic test_extremes();
        test_reset();
        step(1, 1, -65536, 0, 0, "extreme");
        step(1, 0, -65536, 0, 0, "extreme");
        step(1, 0, -65536, 0, 0, "extreme");
        step(1, 0, 65535, 0, 0, "extreme");
        step(0, 0, 0, 0, 1, "extreme_flush");
        step(0, 0, 0, 0, 1, "extreme_flush");
        step(1, 1, 65535, -65536, 0, "extreme_im");
        step(1, 0, -65536, 65535, 0, "extreme_im");
        step(1, 0, -65536, 65535, 0, "extreme_im");
        step(1, 0, 65535, -65536, 0, "extreme_im");
        step(0, 0, 0, 0, 1, "extreme_im_flush");
        step(0, 0, 0, 0, 1, "extreme_im_flush");
    endtask

    task automatic test_back_to_back();
        test_reset();
        frame(4, 0, "b2b");
        frame(4, 0, "b2b");
        step(0, 0, 0, 0, 1, "b2b_flush");
        step(0, 0, 0, 0, 1, "b2b_flush");
        idle("b2b_idle");
    endtask

    task automatic test_sof_mid();
        test_reset();
        frame(4, 0, "sofmid_a");
        step(1, 1, rnd_s(), rnd_s(), 0, "sofmid_b");
        step(1, 0, rnd_s(), rnd_s(), 0, "sofmid_b");
        frame(4, 0, "sofmid_c");
        step(1, 1, rnd_s(), rnd_s(), 0, "sofmid_d");
        frame(4, 0, "sofmid_e");
        step(0, 0, 0, 0, 1, "sofmid_flush");
        step(0, 0, 0, 0, 1, "sofmid_flush");
        frame(4, 0, "sofmid_after_flush");
        step(0, 0, 0, 0, 1, "sofmid_flush2");
        step(0, 0, 0, 0, 1, "sofmid_flush2");
    endtask

    task automatic test_gaps();
        test_reset();
        for (int f = 0; f < 4; f++) frame(4, 1, "gaps");
        step(0, 0, 0, 0, 1, "gaps_flush");
        idle("gaps_idle");
        step(0, 0, 0, 0, 1, "gaps_flush");
        step(0, 0, 0, 0, 1, "gaps_flush_cnt2");
        idle("gaps_idle");
    endtask

    task automatic test_reset_mid();
        test_reset();
        frame(4, 0, "rstmid_a");
        step(1, 1, rnd_s(), rnd_s(), 0, "rstmid_b");
        step(1, 0, rnd_s(), rnd_s(), 0, "rstmid_b");
        test_reset();
        frame(4, 0, "rstmid_c");
        step(0, 0, 0, 0, 1, "rstmid_flush");
        step(0, 0, 0, 0, 1, "rstmid_flush");
    endtask

    task automatic test_random_stream();
        test_reset();
        for (int f = 0; f < 40; f++) begin
            int n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
            frame(n, 1'($urandom), "rand");
            if ($urandom_range(0, 9) == 0 && ph == 0) begin
                step(0, 0, 0, 0, 1, "rand_flush");
                step(0, 0, 0, 0, 1, "rand_flush");
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_sof = 0; flush = 0; in_re = '0; in_im = '0;
        test_reset();
        test_basic_frame();
        test_extremes();
        test_back_to_back();
        test_sof_mid();
        test_gaps();
        test_reset_mid();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
